// File: rtl/br_param.sv
// Parametrised register bank: two combinational read ports, one clocked write port,
// optional hard-wired zero register, optional write-to-read bypass and a built-in scrub sequencer.
module br_param #(
  parameter int WIDTH    = 32,
  parameter int AWIDTH   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] RR1,
  input  logic [AWIDTH-1:0] RR2,
  input  logic [AWIDTH-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic              Clear,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2,
  output logic              Busy
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SCRUB = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [AWIDTH-1:0] r_ptr;
  logic [AWIDTH-1:0] w_nextPtr;

  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_busy;
  logic              w_zeroTarget;
  logic              w_writeAccept;
  logic              w_memWe;
  logic [AWIDTH-1:0] w_memAddr;
  logic [WIDTH-1:0]  w_memData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCRUB;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
    end
  end

  // Clear is only honoured from IDLE, so a request during a scrub neither restarts nor extends it.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (Clear) begin
          w_nextState = ST_SCRUB;
          w_nextPtr   = '0;
        end
      end
      ST_SCRUB: begin
        if (r_ptr == LAST_PTR) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextPtr = r_ptr + AWIDTH'(1);
        end
      end
      default: begin
        w_nextState = ST_SCRUB;
        w_nextPtr   = '0;
      end
    endcase
  end

  assign w_busy        = (r_state == ST_SCRUB);
  assign w_zeroTarget  = ZERO_REG && (WriteReg == '0);
  assign w_writeAccept = RegWrite && !w_busy && !w_zeroTarget;

  // Single write port shared by the scrubber and user writes; the state is SCRUB while reset is held.
  always_comb begin
    w_memWe   = 1'b0;
    w_memAddr = WriteReg;
    w_memData = WriteData;
    if (w_busy) begin
      w_memWe   = 1'b1;
      w_memAddr = r_ptr;
      w_memData = '0;
    end else if (w_writeAccept) begin
      w_memWe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  function automatic logic [WIDTH-1:0] readPort(
    input logic              busy,
    input logic [AWIDTH-1:0] addr,
    input logic              accept,
    input logic [AWIDTH-1:0] wAddr,
    input logic [WIDTH-1:0]  wData,
    input logic [WIDTH-1:0]  memWord
  );
    logic [WIDTH-1:0] result;
    result = memWord;
    if (busy) begin
      result = '0;
    end else if (ZERO_REG && (addr == '0)) begin
      result = '0;
    end else if (BYPASS && accept && (wAddr == addr)) begin
      result = wData;
    end
    return result;
  endfunction

  always_comb begin
    RD1 = readPort(w_busy, RR1, w_writeAccept, WriteReg, WriteData, r_mem[RR1]);
    RD2 = readPort(w_busy, RR2, w_writeAccept, WriteReg, WriteData, r_mem[RR2]);
  end

  assign Busy = w_busy;

endmodule

// File: tb/tb_br_param.sv
// Directed, table-driven bench for br_param with hand-written sequences for scrub, Clear and reset.
module tb_br_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RR1, RR2, WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite, Clear;
  logic [31:0] RD1, RD2;
  logic        Busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] expMem [32];

  always #5 clk = ~clk;

  br_param #(.WIDTH(32), .AWIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .RR1(RR1), .RR2(RR2), .WriteReg(WriteReg),
    .WriteData(WriteData), .RegWrite(RegWrite), .Clear(Clear),
    .RD1(RD1), .RD2(RD2), .Busy(Busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] wreg,
                               input logic [31:0] wdata, input logic we, input logic clr);
    RR1 = rr1; RR2 = rr2; WriteReg = wreg; WriteData = wdata; RegWrite = we; Clear = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic countScrubEdges(output int edges);
    edges = 0;
    while (Busy && edges < 200) begin
      step();
      edges++;
    end
  endtask

  initial begin
    int edges;
    logic bad;

    vecs[0] = '{5'd6,  5'd5,  5'd5,  32'hDEADBEEF, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{5'd5,  5'd6,  5'd0,  32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{5'd0,  5'd5,  5'd0,  32'hFFFFFFFF, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        32'h0};
    vecs[4] = '{5'd7,  5'd7,  5'd7,  32'h000000A5, 1'b1, 32'h000000A5, 32'h000000A5};
    vecs[5] = '{5'd5,  5'd7,  5'd5,  32'h11111111, 1'b1, 32'h11111111, 32'h000000A5};
    vecs[6] = '{5'd5,  5'd7,  5'd0,  32'h0,        1'b0, 32'h11111111, 32'h000000A5};
    vecs[7] = '{5'd9,  5'd31, 5'd9,  32'h00000055, 1'b0, 32'h0,        32'h0};
    vecs[8] = '{5'd31, 5'd30, 5'd31, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h0};
    vecs[9] = '{5'd30, 5'd31, 5'd0,  32'h0,        1'b0, 32'h0,        32'hCAFEF00D};

    reset = 1'b1;
    applyStimulus(5'h1F, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("resetBusy", 32'(Busy), 32'd1);
    checkOutput("resetRD1", RD1, 32'h0);
    checkOutput("resetRD2", RD2, 32'h0);
    step();
    step();

    reset = 1'b0;
    applyStimulus(5'd3, 5'h1F, 5'd3, 32'h00001234, 1'b1, 1'b0);
    edges = 0;
    bad = 1'b0;
    while (Busy && edges < 200) begin
      if (RD1 !== 32'h0 || RD2 !== 32'h0) bad = 1'b1;
      RR1 = 5'(edges);
      #1;
      if (RD1 !== 32'h0) bad = 1'b1;
      step();
      edges++;
    end
    applyStimulus(5'd3, 5'h1F, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("initScrubEdges", 32'(edges), 32'd32);
    checkOutput("initScrubReadsZero", 32'(bad), 32'd0);
    checkOutput("idleBusy", 32'(Busy), 32'd0);
    checkOutput("writeDuringBusyDropped", RD1, 32'h0);
    checkOutput("reg31AfterScrub", RD2, 32'h0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rr1, vecs[i].rr2, vecs[i].wreg, vecs[i].wdata, vecs[i].we, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d.RD1", i), RD1, vecs[i].exp1);
      checkOutput($sformatf("vec%0d.RD2", i), RD2, vecs[i].exp2);
      checkOutput($sformatf("vec%0d.Busy", i), 32'(Busy), 32'd0);
      step();
    end

    expMem[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      expMem[i] = i * 32'h01010101;
      applyStimulus(5'd0, 5'd0, 5'(i), expMem[i], 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("fill.RD1[%0d]", i), RD1, expMem[i]);
      checkOutput($sformatf("fill.RD2[%0d]", 31 - i), RD2, expMem[31 - i]);
    end

    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    step();
    applyStimulus(5'd4, 5'd0, 5'd4, 32'h00000BAD, 1'b1, 1'b0);
    #1;
    checkOutput("clearBusyRise", 32'(Busy), 32'd1);
    edges = 0;
    while (Busy && edges < 200) begin
      Clear = (edges == 9);
      step();
      edges++;
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("doubleClearEdges", 32'(edges), 32'd32);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("cleared.RD1[%0d]", i), RD1, 32'h0);
      checkOutput($sformatf("cleared.RD2[%0d]", 31 - i), RD2, 32'h0);
    end

    applyStimulus(5'd2, 5'd2, 5'd2, 32'h00000077, 1'b1, 1'b1);
    #1;
    checkOutput("clearWriteBypass", RD1, 32'h00000077);
    step();
    applyStimulus(5'd2, 5'd2, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("clearWriteBusy", 32'(Busy), 32'd1);
    countScrubEdges(edges);
    checkOutput("clearWriteEdges", 32'(edges), 32'd32);
    checkOutput("clearWriteErased", RD1, 32'h0);

    applyStimulus(5'd12, 5'd12, 5'd12, 32'h00000C0C, 1'b1, 1'b0);
    step();
    applyStimulus(5'd12, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("reg12Written", RD1, 32'h00000C0C);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", 32'(Busy), 32'd1);
    checkOutput("midResetRD1", RD1, 32'h0);
    step();
    step();
    checkOutput("midResetHeldBusy", 32'(Busy), 32'd1);
    reset = 1'b0;
    countScrubEdges(edges);
    checkOutput("midResetScrubEdges", 32'(edges), 32'd32);
    checkOutput("midResetReg12", RD1, 32'h0);
    checkOutput("midResetReg31", RD2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
